// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: command indices, R1 bits, tokens and FSM states shared by the SD SPI card target
package sd_spi_pkg;
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam logic [7:0] R1_IDLE    = 8'(1) << R1_IDLE_BIT;
    localparam logic [7:0] R1_ILLEGAL = 8'(1) << R1_ILLEGAL_BIT;
    localparam logic [7:0] TOKEN_START       = 8'hFE;
    localparam logic [7:0] TOKEN_DATA_ACCEPT = 8'h05;
    typedef enum logic [3:0] {
        IDLE, CMD, NCR, R1, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: oversampled SPI mode-0 byte engine (sync, edge detect, shift registers, bit count)
module spi_byte_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic       cs_high,
    output logic       byte_done,
    output logic [7:0] rx_byte
);
    logic [1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic       rise, fall, tx_load;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], spi_sclk};
        cs_sync_d   = {cs_sync_q[0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        sclk_prev_d = sclk_sync_q[1];
        rise        = sclk_sync_q[1] & ~sclk_prev_q;
        fall        = ~sclk_sync_q[1] & sclk_prev_q;
        cs_high     = cs_sync_q[1];
        byte_done   = rise & ~cs_high & (bit_cnt_q == 3'd7);
        tx_load     = byte_done;
        rx_byte     = {rx_sr_q[6:0], mosi_sync_q[1]};
        bit_cnt_d   = cs_high ? 3'd0 : bit_cnt_q + 3'(rise);
        rx_sr_d     = rise ? rx_byte : rx_sr_q;
        // the falling edge that follows a byte boundary keeps the freshly loaded bit 7
        tx_sr_d     = cs_high ? 8'hFF
                    : tx_load ? tx_byte
                    : (fall && bit_cnt_q != 3'd0) ? {tx_sr_q[6:0], 1'b1}
                    : tx_sr_q;
        spi_miso    = cs_high | tx_sr_q[7];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b11;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'hFF;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
        end
    end
endmodule

// File: rtl/sd_spi_card.sv
// sd_spi_card: SPI-mode SD card target with R1 responses and single-block read/write to a byte memory
module sd_spi_card
    import sd_spi_pkg::*;
#(
    parameter int NCR_BYTES   = 2,
    parameter int BLOCK_BYTES = 512,
    parameter int BUSY_BYTES  = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr,
    output logic [7:0]        mem_wr_data,
    output logic              cmd_valid,
    output logic [5:0]        cmd_index,
    output logic [31:0]       cmd_arg
);
    localparam int CW = 16;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [5:0]        cmd_index_q, cmd_index_d;
    logic [31:0]       cmd_arg_q, cmd_arg_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        rd_data_q, rd_data_d, r1_q, r1_d, r1_val, tx_byte, rx_byte;
    logic              idle_flag_q, idle_flag_d, acmd_q, acmd_d, cmd_valid_q, cmd_valid_d;
    logic              mem_rd_q, mem_rd_d, rd_pend_q, rd_pend_d;
    logic              cs_high, byte_done, rd_go, wr_go;

    spi_byte_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .tx_byte   (tx_byte),
        .spi_miso  (spi_miso),
        .cs_high   (cs_high),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    always_comb begin
        r1_val = cmd_index_q == CMD0 ? R1_IDLE
               : cmd_index_q == CMD55 ? {7'b0, idle_flag_q}
               : (acmd_q && cmd_index_q == ACMD41) ? 8'h00
               : (cmd_index_q == CMD17 || cmd_index_q == CMD24) ? (idle_flag_q ? (R1_ILLEGAL | R1_IDLE) : 8'h00)
               : R1_ILLEGAL | {7'b0, idle_flag_q};
        rd_go       = r1_q == 8'h00 && cmd_index_q == CMD17;
        wr_go       = r1_q == 8'h00 && cmd_index_q == CMD24;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        mem_addr_d  = mem_addr_q;
        r1_d        = r1_q;
        idle_flag_d = idle_flag_q;
        acmd_d      = acmd_q;
        cmd_valid_d = 1'b0;
        mem_rd_d    = 1'b0;
        rd_pend_d   = mem_rd_q;
        rd_data_d   = rd_pend_q ? mem_rd_data : rd_data_q;
        tx_byte     = 8'hFF;
        mem_wr      = byte_done && state_q == WR_DATA;
        mem_wr_data = mem_wr ? rx_byte : 8'h00;
        if (byte_done) begin
            cnt_d = cnt_q + CW'(1);
            case (state_q)
                IDLE: if (rx_byte[7:6] == 2'b01) begin
                    state_d     = CMD;
                    cmd_index_d = rx_byte[5:0];
                    cnt_d       = '0;
                end
                CMD: begin
                    if (!cnt_q[2]) cmd_arg_d = {cmd_arg_q[23:0], rx_byte};
                    if (cnt_q == CW'(4)) begin
                        state_d     = NCR;
                        cnt_d       = '0;
                        cmd_valid_d = 1'b1;
                    end
                end
                NCR: if (cnt_q == CW'(NCR_BYTES - 1)) begin
                    state_d     = R1;
                    tx_byte     = r1_val;
                    r1_d        = r1_val;
                    idle_flag_d = cmd_index_q == CMD0 ? 1'b1
                                : (acmd_q && cmd_index_q == ACMD41) ? 1'b0 : idle_flag_q;
                    acmd_d      = cmd_index_q == CMD55;
                end
                R1: begin
                    state_d    = rd_go ? RD_TOKEN : wr_go ? WR_TOKEN : IDLE;
                    cnt_d      = '0;
                    mem_addr_d = cmd_arg_q[ADDR_W-1:0];
                    mem_rd_d   = rd_go;
                    tx_byte    = rd_go ? TOKEN_START : 8'hFF;
                end
                RD_TOKEN: begin
                    state_d    = RD_DATA;
                    cnt_d      = '0;
                    tx_byte    = rd_data_q;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
                RD_DATA: if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
                    state_d = RD_CRC;
                    cnt_d   = '0;
                end else begin
                    tx_byte    = rd_data_q;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
                RD_CRC: if (cnt_q == CW'(1)) state_d = IDLE;
                WR_TOKEN: if (rx_byte == TOKEN_START) begin
                    state_d = WR_DATA;
                    cnt_d   = '0;
                end
                WR_DATA: begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        state_d = WR_CRC;
                        cnt_d   = '0;
                    end
                end
                WR_CRC: if (cnt_q == CW'(1)) begin
                    state_d = WR_RESP;
                    tx_byte = TOKEN_DATA_ACCEPT;
                end
                WR_RESP: begin
                    state_d = WR_BUSY;
                    cnt_d   = '0;
                    tx_byte = 8'h00;
                end
                WR_BUSY: if (cnt_q == CW'(BUSY_BYTES - 1)) state_d = IDLE;
                         else tx_byte = 8'h00;
                default: state_d = IDLE;
            endcase
        end
        if (cs_high) begin
            state_d  = IDLE;
            cnt_d    = '0;
            mem_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            mem_addr_q  <= '0;
            r1_q        <= 8'hFF;
            idle_flag_q <= 1'b1;
            acmd_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            mem_addr_q  <= mem_addr_d;
            r1_q        <= r1_d;
            idle_flag_q <= idle_flag_d;
            acmd_q      <= acmd_d;
            cmd_valid_q <= cmd_valid_d;
            mem_rd_q    <= mem_rd_d;
            rd_pend_q   <= rd_pend_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_index = cmd_index_q;
    assign cmd_arg   = cmd_arg_q;
endmodule

// File: tb/tb_sd_spi_card.sv
// tb_sd_spi_card: directed SPI host driving the SD card target against a mem[i]=i[7:0] memory model
module tb_sd_spi_card;
    import sd_spi_pkg::*;
    localparam int NCR = 2, BLK = 512, BUSY = 4, AW = 16;

    logic          clk = 1'b0, reset = 1'b1;
    logic          spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b1;
    logic          spi_miso, mem_rd, mem_wr, cmd_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = 8'h00, mem_wr_data;
    logic [5:0]    cmd_index;
    logic [31:0]   cmd_arg;
    int            checks = 0, failures = 0;
    int            cv_cnt = 0, rd_cnt = 0, wr_cnt = 0, wr_bad = 0;

    sd_spi_card #(.NCR_BYTES(NCR), .BLOCK_BYTES(BLK), .BUSY_BYTES(BUSY), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data),
        .mem_wr(mem_wr), .mem_wr_data(mem_wr_data), .cmd_valid(cmd_valid),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rd_data <= mem_addr[7:0];

    always @(negedge clk) begin
        if (cmd_valid) cv_cnt++;
        if (mem_rd) rd_cnt++;
        if (mem_wr) begin
            if (mem_addr !== 16'(16'h0100 + wr_cnt) || mem_wr_data !== 8'hA5) wr_bad++;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #40;
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #40;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                            output logic [7:0] r1, output int bad);
        logic [7:0] b;
        bad = 0;
        xfer({2'b01, idx}, b);
        if (b !== 8'hFF) bad++;
        for (int k = 0; k < 4; k++) begin
            xfer(arg[31 - 8 * k -: 8], b);
            if (b !== 8'hFF) bad++;
        end
        xfer(8'h95, b);
        if (b !== 8'hFF) bad++;
        for (int k = 0; k < NCR; k++) begin
            xfer(8'hFF, b);
            if (b !== 8'hFF) bad++;
        end
        xfer(8'hFF, r1);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100;
        spi_cs_n = 1'b1;
        #100;
    endtask

    initial begin
        logic [7:0] b, r1, b15, b16;
        int bad, n0;
        repeat (5) @(posedge clk);
        #5;
        check("rst_miso", 32'(spi_miso), 1);
        check("rst_strobes", {mem_rd, mem_wr, cmd_valid}, 0);
        check("rst_addr_wdata", {mem_addr, mem_wr_data}, 0);
        check("rst_cmd", {cmd_index, cmd_arg[25:0]}, 0);
        reset = 1'b0;
        #100;

        cs_low();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'hFF) bad++;
        end
        check("ff_idle_miso", bad, 0);
        check("ff_no_cmd_valid", cv_cnt, 0);
        cs_high();

        cs_low();
        send_cmd(CMD0, 32'h0, r1, bad);
        check("cmd0_r1", r1, 8'h01);
        check("cmd0_filler", bad, 0);
        check("cmd0_valid_cnt", cv_cnt, 1);
        check("cmd0_index", cmd_index, 0);
        send_cmd(CMD55, 32'h0, r1, bad);
        check("cmd55_r1", r1, 8'h01);
        send_cmd(ACMD41, 32'h4000_0000, r1, bad);
        check("acmd41_r1", r1, 8'h00);
        send_cmd(6'd8, 32'h0000_01AA, r1, bad);
        check("cmd8_r1", r1, 8'h04);
        check("cmd8_arg", cmd_arg, 32'h0000_01AA);
        check("cmd8_index", cmd_index, 8);
        check("cmd_valid_cnt4", cv_cnt, 4);

        n0 = rd_cnt;
        send_cmd(CMD17, 32'h0000_FFF0, r1, bad);
        check("cmd17_r1", r1, 8'h00);
        b = 8'hFF;
        for (int n = 0; n < 8 && b != 8'hFE; n++) xfer(8'hFF, b);
        check("rd_token", b, 8'hFE);
        bad = 0;
        b15 = 8'h00;
        b16 = 8'hFF;
        for (int i = 0; i < BLK; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'(8'hF0 + i)) bad++;
            if (i == 15) b15 = b;
            if (i == 16) b16 = b;
        end
        check("rd_data_bad", bad, 0);
        check("rd_byte_ffff", b15, 8'hFF);
        check("rd_byte_wrap0", b16, 8'h00);
        xfer(8'hFF, b);
        check("rd_crc0", b, 8'hFF);
        xfer(8'hFF, b);
        check("rd_crc1", b, 8'hFF);
        check("rd_mem_rd_cnt", rd_cnt - n0, BLK + 1);
        cs_high();

        cs_low();
        send_cmd(CMD24, 32'h0000_0100, r1, bad);
        check("cmd24_r1", r1, 8'h00);
        xfer(8'hFF, b);
        check("wr_wait_token", b, 8'hFF);
        xfer(8'hFE, b);
        for (int i = 0; i < BLK; i++) xfer(8'hA5, b);
        xfer(8'h12, b);
        xfer(8'h34, b);
        check("wr_cnt", wr_cnt, BLK);
        check("wr_addr_data_bad", wr_bad, 0);
        xfer(8'hFF, b);
        check("wr_resp", b, 8'h05);
        bad = 0;
        for (int i = 0; i < BUSY; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'h00) bad++;
        end
        check("wr_busy", bad, 0);
        xfer(8'hFF, b);
        check("wr_after_busy", b, 8'hFF);
        cs_high();

        cs_low();
        send_cmd(CMD17, 32'h0, r1, bad);
        check("abort_r1", r1, 8'h00);
        for (int i = 0; i < 100; i++) xfer(8'hFF, b);
        #40;
        spi_cs_n = 1'b1;
        #200;
        check("abort_miso", 32'(spi_miso), 1);
        check("abort_fsm_idle", 32'(dut.state_q), 32'(IDLE));
        n0 = rd_cnt;
        #3000;
        check("abort_no_rd", rd_cnt - n0, 0);
        cs_low();
        send_cmd(CMD0, 32'h0, r1, bad);
        check("abort_cmd0_r1", r1, 8'h01);
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
